// File: rtl/dma_copy_engine.sv
// Memory-to-memory word copier: CPU-programmed slave registers plus a single-outstanding-read
// bus master that moves COUNTWIDTH-bounded blocks of 32-bit words from SRC to DST.
module dma_copy_engine #(
  parameter int unsigned COUNTWIDTH = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [2:0]  i_address,
  input  logic [31:0] i_data_in,
  output logic        o_read_valid,
  output logic [31:0] o_data_out,
  output logic        o_irq,
  output logic        o_master_read,
  output logic        o_master_write,
  output logic [3:0]  o_master_bwe,
  output logic [31:0] o_master_address,
  output logic [31:0] o_master_data_out,
  input  logic        i_master_wait_request,
  input  logic        i_master_read_valid,
  input  logic [31:0] i_master_data_in
);

  typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWrReq, StDone} state_e;

  state_e                  r_state;
  logic [31:0]             r_src;
  logic [31:0]             r_dst;
  logic [COUNTWIDTH-1:0]   r_count;
  logic                    r_irq_en;
  logic                    r_done;
  logic                    r_aborted;
  logic                    r_abort_pend;

  logic        w_busy;
  logic        w_ctrl_wr;
  logic        w_start;
  logic        w_abort;
  logic [31:0] w_rd_data;

  assign w_busy    = (r_state != StIdle);
  assign w_ctrl_wr = i_write && (i_address == 3'd3);
  // Abort and start in the same write: abort wins.
  assign w_start   = w_ctrl_wr && i_data_in[0] && !i_data_in[2];
  assign w_abort   = w_ctrl_wr && i_data_in[2];
  assign o_irq     = r_irq_en && (r_done || r_aborted);

  always_comb begin
    w_rd_data = 32'd0;
    case (i_address)
      3'd0:    w_rd_data = r_src;
      3'd1:    w_rd_data = r_dst;
      3'd2:    w_rd_data = 32'(r_count);
      3'd3:    w_rd_data = {30'd0, r_irq_en, 1'b0};
      3'd4:    w_rd_data = {29'd0, r_aborted, r_done, w_busy};
      default: w_rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state           <= StIdle;
      r_src             <= 32'd0;
      r_dst             <= 32'd0;
      r_count           <= '0;
      r_irq_en          <= 1'b0;
      r_done            <= 1'b0;
      r_aborted         <= 1'b0;
      r_abort_pend      <= 1'b0;
      o_read_valid      <= 1'b0;
      o_data_out        <= 32'd0;
      o_master_read     <= 1'b0;
      o_master_write    <= 1'b0;
      o_master_bwe      <= 4'd0;
      o_master_address  <= 32'd0;
      o_master_data_out <= 32'd0;
    end else begin
      o_read_valid <= i_read;
      o_data_out   <= i_read ? w_rd_data : 32'd0;

      if (i_write && !w_busy) begin
        if (i_address == 3'd0) r_src   <= i_data_in;
        if (i_address == 3'd1) r_dst   <= i_data_in;
        if (i_address == 3'd2) r_count <= i_data_in[COUNTWIDTH-1:0];
      end
      if (w_ctrl_wr) r_irq_en <= i_data_in[1];
      if (i_write && (i_address == 3'd4)) begin
        if (i_data_in[1]) r_done    <= 1'b0;
        if (i_data_in[2]) r_aborted <= 1'b0;
      end
      if (w_abort && w_busy) r_abort_pend <= 1'b1;

      // FSM status updates follow the register writes so a completion beats a same-cycle clear.
      case (r_state)
        StIdle: begin
          if (w_start) begin
            if (r_count == '0) begin
              r_done <= 1'b1;
            end else begin
              r_done           <= 1'b0;
              r_aborted        <= 1'b0;
              r_abort_pend     <= 1'b0;
              o_master_read    <= 1'b1;
              o_master_address <= {r_src[31:2], 2'b00};
              r_state          <= StRdReq;
            end
          end
        end
        StRdReq: begin
          if (!i_master_wait_request) begin
            o_master_read    <= 1'b0;
            o_master_address <= 32'd0;
            r_state          <= StRdWait;
          end
        end
        StRdWait: begin
          if (i_master_read_valid) begin
            if (r_abort_pend) begin
              r_abort_pend <= 1'b0;
              r_aborted    <= 1'b1;
              r_state      <= StIdle;
            end else begin
              r_src             <= r_src + 32'd4;
              o_master_write    <= 1'b1;
              o_master_bwe      <= 4'hF;
              o_master_address  <= {r_dst[31:2], 2'b00};
              o_master_data_out <= i_master_data_in;
              r_state           <= StWrReq;
            end
          end
        end
        StWrReq: begin
          if (!i_master_wait_request) begin
            o_master_write    <= 1'b0;
            o_master_bwe      <= 4'd0;
            o_master_address  <= 32'd0;
            o_master_data_out <= 32'd0;
            r_dst             <= r_dst + 32'd4;
            r_count           <= r_count - 1'b1;
            if (r_abort_pend) begin
              r_abort_pend <= 1'b0;
              r_aborted    <= 1'b1;
              r_state      <= StIdle;
            end else if (r_count == COUNTWIDTH'(1)) begin
              r_state <= StDone;
            end else begin
              o_master_read    <= 1'b1;
              o_master_address <= {r_src[31:2], 2'b00};
              r_state          <= StRdReq;
            end
          end
        end
        StDone: begin
          r_done  <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine: register-access vector table plus hand-written
// transfer sequences against a simple bus slave with controllable stalls.
module tb_dma_copy_engine;

  logic        clk = 1'b0;
  logic        i_reset, i_read, i_write;
  logic [2:0]  i_address;
  logic [31:0] i_data_in;
  logic        o_read_valid, o_irq, o_master_read, o_master_write;
  logic [31:0] o_data_out, o_master_address, o_master_data_out;
  logic [3:0]  o_master_bwe;
  logic        mwait, slv_rv;
  logic [31:0] slv_rdata;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] dst_mem [256];
  logic        rv_hold;
  logic        slv_pend;
  logic [31:0] slv_pend_data;
  int          n_reads, n_writes;
  logic [31:0] last_rd_addr, prev_rd_addr;

  always #5 clk = ~clk;

  dma_copy_engine #(.COUNTWIDTH(16)) dut (
    .i_clk                 (clk),
    .i_reset               (i_reset),
    .i_read                (i_read),
    .i_write               (i_write),
    .i_address             (i_address),
    .i_data_in             (i_data_in),
    .o_read_valid          (o_read_valid),
    .o_data_out            (o_data_out),
    .o_irq                 (o_irq),
    .o_master_read         (o_master_read),
    .o_master_write        (o_master_write),
    .o_master_bwe          (o_master_bwe),
    .o_master_address      (o_master_address),
    .o_master_data_out     (o_master_data_out),
    .i_master_wait_request (mwait),
    .i_master_read_valid   (slv_rv),
    .i_master_data_in      (slv_rdata)
  );

  function automatic logic [31:0] pattern(input logic [31:0] a);
    return (a * 32'd7) ^ 32'h5A5A_0000;
  endfunction

  // Bus slave: source data is a function of address, writes land in dst_mem.
  always @(posedge clk) begin
    if (i_reset) begin
      for (int i = 0; i < 256; i++) dst_mem[i] <= 32'd0;
      slv_rv       <= 1'b0;
      slv_rdata    <= 32'd0;
      slv_pend     <= 1'b0;
      n_reads      <= 0;
      n_writes     <= 0;
      last_rd_addr <= 32'd0;
      prev_rd_addr <= 32'd0;
    end else begin
      slv_rv <= 1'b0;
      if (slv_pend && !rv_hold) begin
        slv_rv    <= 1'b1;
        slv_rdata <= slv_pend_data;
        slv_pend  <= 1'b0;
      end
      if (o_master_read && !mwait) begin
        slv_pend      <= 1'b1;
        slv_pend_data <= pattern(o_master_address);
        n_reads       <= n_reads + 1;
        prev_rd_addr  <= last_rd_addr;
        last_rd_addr  <= o_master_address;
      end
      if (o_master_write && !mwait) begin
        dst_mem[o_master_address[9:2]] <= o_master_data_out;
        n_writes <= n_writes + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    i_write = 1'b1; i_address = a; i_data_in = d;
    @(negedge clk);
    i_write = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d, output logic v);
    i_read = 1'b1; i_address = a;
    @(negedge clk);
    i_read = 1'b0;
    d = o_data_out;
    v = o_read_valid;
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] d;
    logic        v;
    d = 32'd1;
    for (int i = 0; i < 300; i++) begin
      reg_read(3'd4, d, v);
      if (!d[0]) break;
    end
    check(name, 32'(d[0]), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic        do_wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] rd, a0, d0;
  logic        vld;
  int          base_r, base_w, found;

  initial begin
    i_reset = 1'b1; i_read = 1'b0; i_write = 1'b0; i_address = 3'd0; i_data_in = 32'd0;
    mwait = 1'b0; rv_hold = 1'b0;

    vecs[0] = '{3'd0, 1'b0, 32'h0,         32'h0};
    vecs[1] = '{3'd0, 1'b1, 32'h1234_5677, 32'h1234_5677};
    vecs[2] = '{3'd1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3] = '{3'd2, 1'b1, 32'h0001_2345, 32'h0000_2345};
    vecs[4] = '{3'd3, 1'b1, 32'h0000_0002, 32'h0000_0002};
    vecs[5] = '{3'd4, 1'b0, 32'h0,         32'h0};
    vecs[6] = '{3'd3, 1'b1, 32'h0000_0005, 32'h0000_0000};
    vecs[7] = '{3'd4, 1'b0, 32'h0,         32'h0};
    vecs[8] = '{3'd5, 1'b0, 32'h0,         32'h0};
    vecs[9] = '{3'd6, 1'b1, 32'hFFFF_FFFF, 32'h0};

    repeat (3) @(negedge clk);
    i_reset = 1'b0;

    // Reset state
    check("rst read_valid", 32'(o_read_valid), 32'd0);
    check("rst irq", 32'(o_irq), 32'd0);
    check("rst master_read", 32'(o_master_read), 32'd0);
    check("rst master_write", 32'(o_master_write), 32'd0);
    check("rst master_addr", o_master_address, 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].do_wr) reg_write(vecs[i].addr, vecs[i].wdata);
      reg_read(vecs[i].addr, rd, vld);
      check($sformatf("vec%0d valid", i), 32'(vld), 32'd1);
      check($sformatf("vec%0d data", i), rd, vecs[i].exp);
    end
    @(negedge clk);
    check("idle read_valid", 32'(o_read_valid), 32'd0);
    check("idle data_out", o_data_out, 32'd0);
    check("abort+start no bus read", 32'(n_reads), 32'd0);

    // Basic 3-word copy, zero wait
    reg_write(3'd0, 32'h100); reg_write(3'd1, 32'h200); reg_write(3'd2, 32'd3);
    reg_write(3'd3, 32'h1);
    wait_idle("t1 finish");
    for (int i = 0; i < 3; i++)
      check($sformatf("t1 dst%0d", i), dst_mem[128 + i], pattern(32'h100 + 32'(4 * i)));
    reg_read(3'd4, rd, vld); check("t1 status", rd, 32'h2);
    reg_read(3'd2, rd, vld); check("t1 count", rd, 32'd0);
    reg_read(3'd0, rd, vld); check("t1 src", rd, 32'h10C);
    reg_read(3'd1, rd, vld); check("t1 dst", rd, 32'h20C);
    check("t1 reads", 32'(n_reads), 32'd3);
    check("t1 writes", 32'(n_writes), 32'd3);

    // Stall on second write
    reg_write(3'd0, 32'h140); reg_write(3'd1, 32'h280); reg_write(3'd2, 32'd3);
    base_w = n_writes;
    reg_write(3'd3, 32'h1);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (o_master_write && n_writes == base_w + 1) begin found = 1; break; end
      @(negedge clk);
    end
    check("t2 second write seen", 32'(found), 32'd1);
    mwait = 1'b1;
    a0 = o_master_address; d0 = o_master_data_out;
    check("t2 write addr", a0, 32'h284);
    check("t2 write data", d0, pattern(32'h144));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t2 hold write %0d", i), 32'(o_master_write), 32'd1);
      check($sformatf("t2 hold addr %0d", i), o_master_address, a0);
      check($sformatf("t2 hold data %0d", i), o_master_data_out, d0);
    end
    mwait = 1'b0;
    wait_idle("t2 finish");
    for (int i = 0; i < 3; i++)
      check($sformatf("t2 dst%0d", i), dst_mem[160 + i], pattern(32'h140 + 32'(4 * i)));

    // Zero-length start with irq
    reg_write(3'd4, 32'h6); reg_write(3'd2, 32'd0);
    base_r = n_reads;
    reg_write(3'd3, 32'h3);
    reg_read(3'd4, rd, vld); check("t3 status", rd, 32'h2);
    check("t3 irq set", 32'(o_irq), 32'd1);
    check("t3 no bus read", 32'(n_reads - base_r), 32'd0);
    reg_write(3'd4, 32'h2);
    check("t3 irq cleared", 32'(o_irq), 32'd0);

    // Abort while waiting for word 4
    reg_write(3'd0, 32'h100); reg_write(3'd1, 32'h300); reg_write(3'd2, 32'd10);
    base_r = n_reads; base_w = n_writes;
    reg_write(3'd3, 32'h1);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (n_writes - base_w == 3) begin rv_hold = 1'b1; found = 1; break; end
      @(negedge clk);
    end
    check("t4 third write seen", 32'(found), 32'd1);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (n_reads - base_r == 4) begin found = 1; break; end
      @(negedge clk);
    end
    check("t4 fourth read seen", 32'(found), 32'd1);
    reg_write(3'd3, 32'h4);
    rv_hold = 1'b0;
    wait_idle("t4 finish");
    reg_read(3'd4, rd, vld); check("t4 status", rd, 32'h4);
    reg_read(3'd2, rd, vld); check("t4 count", rd, 32'd7);
    check("t4 writes", 32'(n_writes - base_w), 32'd3);
    check("t4 word3 written", dst_mem[194], pattern(32'h108));
    check("t4 word4 not written", dst_mem[195], 32'd0);
    check("t4 master_read low", 32'(o_master_read), 32'd0);
    check("t4 master_write low", 32'(o_master_write), 32'd0);
    check("t4 irq disabled", 32'(o_irq), 32'd0);

    // Address wrap and ignored SRC write while busy
    reg_write(3'd4, 32'h6);
    reg_write(3'd0, 32'hFFFF_FFFC); reg_write(3'd1, 32'h380); reg_write(3'd2, 32'd2);
    reg_write(3'd3, 32'h1);
    reg_write(3'd0, 32'h500);
    wait_idle("t5 finish");
    check("t5 first read addr", prev_rd_addr, 32'hFFFF_FFFC);
    check("t5 second read addr", last_rd_addr, 32'h0);
    reg_read(3'd0, rd, vld); check("t5 src wrapped", rd, 32'h4);
    check("t5 dst0", dst_mem[224], pattern(32'hFFFF_FFFC));
    check("t5 dst1", dst_mem[225], pattern(32'h0));
    reg_read(3'd4, rd, vld); check("t5 status", rd, 32'h2);

    // Reset during a stalled write
    reg_write(3'd3, 32'h2);
    reg_write(3'd0, 32'h100); reg_write(3'd1, 32'h3C0); reg_write(3'd2, 32'd2);
    reg_write(3'd3, 32'h3);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (o_master_write) begin found = 1; break; end
      @(negedge clk);
    end
    check("t6 write seen", 32'(found), 32'd1);
    mwait = 1'b1;
    @(negedge clk);
    check("t6 write held", 32'(o_master_write), 32'd1);
    i_reset = 1'b1;
    @(negedge clk);
    check("t6 master_write", 32'(o_master_write), 32'd0);
    check("t6 master_read", 32'(o_master_read), 32'd0);
    check("t6 master_bwe", 32'(o_master_bwe), 32'd0);
    check("t6 master_addr", o_master_address, 32'd0);
    check("t6 master_data", o_master_data_out, 32'd0);
    check("t6 irq", 32'(o_irq), 32'd0);
    check("t6 read_valid", 32'(o_read_valid), 32'd0);
    i_reset = 1'b0; mwait = 1'b0;
    reg_read(3'd4, rd, vld); check("t6 status", rd, 32'd0);
    reg_read(3'd3, rd, vld); check("t6 control", rd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
